// File: rtl/urv_mem_arbiter_pkg.sv
// Shared types for the uRV single-port memory arbiter: grant / return-type
// encoding and the burst-limiter counter width.
package urv_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_NONE  = 2'd0,
    ARB_INSTR = 2'd1,
    ARB_LOAD  = 2'd2,
    ARB_STORE = 2'd3
  } arb_t;

  localparam int unsigned BURST_W = 4;

endpackage

// File: rtl/urv_mem_arbiter.sv
// Shares one single-port synchronous RAM between the uRV fetch and data ports.
// Data wins unless the burst limiter trips; a one-deep slot holds a lost data pulse.
module urv_mem_arbiter
  import urv_mem_arbiter_pkg::*;
#(
  parameter int unsigned g_addr_width   = 16,
  parameter int unsigned g_max_dm_burst = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [31:0]             im_addr_i,
  input  logic                    im_rd_i,
  output logic [31:0]             im_data_o,
  output logic                    im_valid_o,
  input  logic [31:0]             dm_addr_i,
  input  logic [31:0]             dm_data_s_i,
  input  logic [3:0]              dm_data_select_i,
  input  logic                    dm_load_i,
  input  logic                    dm_store_i,
  output logic [31:0]             dm_data_l_o,
  output logic                    dm_load_done_o,
  output logic                    dm_store_done_o,
  output logic                    mem_en_o,
  output logic [3:0]              mem_we_o,
  output logic [g_addr_width-1:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic [31:0]             mem_rdata_i,
  output logic                    err_o
);

  localparam logic [BURST_W-1:0] MAX_BURST = BURST_W'(g_max_dm_burst);

  logic               live_ld, live_st, live_valid, live_conflict;
  logic               pend_valid, pend_store;
  logic [31:0]        pend_addr, pend_data;
  logic [3:0]         pend_sel;
  logic               d_valid, d_store;
  logic [31:0]        d_addr, d_data;
  logic [3:0]         d_sel;
  logic [BURST_W-1:0] burst_cnt, burst_next;
  arb_t               grant, ret_type;
  logic               data_grant, capture, overflow;
  logic [31:0]        sel_addr;
  logic               err;
  logic               unused_addr_bits;

  assign live_conflict = dm_load_i & dm_store_i;
  assign live_ld       = dm_load_i & ~dm_store_i;
  assign live_st       = dm_store_i & ~dm_load_i;
  assign live_valid    = live_ld | live_st;

  always_comb begin
    d_valid = pend_valid | live_valid;
    d_store = pend_valid ? pend_store : live_st;
    d_addr  = pend_valid ? pend_addr  : dm_addr_i;
    d_data  = pend_valid ? pend_data  : dm_data_s_i;
    d_sel   = pend_valid ? pend_sel   : dm_data_select_i;
  end

  always_comb begin
    grant = ARB_NONE;
    if (d_valid && (!im_rd_i || burst_cnt < MAX_BURST))
      grant = d_store ? ARB_STORE : ARB_LOAD;
    else if (im_rd_i)
      grant = ARB_INSTR;
  end

  assign data_grant = (grant == ARB_LOAD) || (grant == ARB_STORE);

  // A live pulse lands in the slot if it lost to the fetch, or if the slot is
  // being drained this cycle; it overflows only when the slot stays occupied.
  assign capture  = live_valid && (pend_valid ? data_grant : !data_grant);
  assign overflow = live_valid && pend_valid && !data_grant;

  always_comb begin
    burst_next = burst_cnt;
    if (!im_rd_i || grant == ARB_INSTR)
      burst_next = '0;
    else if (data_grant && burst_cnt != '1)
      burst_next = burst_cnt + BURST_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_valid <= 1'b0;
      pend_store <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      pend_sel   <= '0;
      burst_cnt  <= '0;
      ret_type   <= ARB_NONE;
      err        <= 1'b0;
    end else begin
      ret_type  <= grant;
      burst_cnt <= burst_next;
      if (live_conflict || overflow)
        err <= 1'b1;
      if (capture) begin
        pend_valid <= 1'b1;
        pend_store <= live_st;
        pend_addr  <= dm_addr_i;
        pend_data  <= dm_data_s_i;
        pend_sel   <= dm_data_select_i;
      end else if (pend_valid && data_grant) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    case (grant)
      ARB_INSTR:           sel_addr = im_addr_i;
      ARB_LOAD, ARB_STORE: sel_addr = d_addr;
      default:             sel_addr = '0;
    endcase
  end

  assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[31:g_addr_width+2]};

  assign mem_en_o    = rst_n_i && (grant != ARB_NONE);
  assign mem_we_o    = (rst_n_i && grant == ARB_STORE) ? d_sel : '0;
  assign mem_addr_o  = rst_n_i ? sel_addr[g_addr_width+1:2] : '0;
  assign mem_wdata_o = (rst_n_i && grant == ARB_STORE) ? d_data : '0;

  assign im_valid_o      = (ret_type == ARB_INSTR);
  assign im_data_o       = im_valid_o ? mem_rdata_i : '0;
  assign dm_load_done_o  = (ret_type == ARB_LOAD);
  assign dm_data_l_o     = dm_load_done_o ? mem_rdata_i : '0;
  assign dm_store_done_o = (ret_type == ARB_STORE);
  assign err_o           = err;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Scoreboard bench for urv_mem_arbiter: a queue-based reference model predicts
// RAM drive and returned words; a negedge monitor checks every DUT output.
module tb_urv_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned MB = 4;

  typedef struct packed {
    logic        st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } op_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   im_addr = '0;
  logic          im_rd = 1'b0;
  logic [31:0]   im_data;
  logic          im_valid;
  logic [31:0]   dm_addr = '0;
  logic [31:0]   dm_wdata = '0;
  logic [3:0]    dm_sel = '0;
  logic          dm_load = 1'b0;
  logic          dm_store = 1'b0;
  logic [31:0]   dm_rdata;
  logic          load_done, store_done;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          err;

  urv_mem_arbiter #(.g_addr_width(AW), .g_max_dm_burst(MB)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_addr_i(im_addr), .im_rd_i(im_rd), .im_data_o(im_data), .im_valid_o(im_valid),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel),
    .dm_load_i(dm_load), .dm_store_i(dm_store), .dm_data_l_o(dm_rdata),
    .dm_load_done_o(load_done), .dm_store_done_o(store_done),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .err_o(err)
  );

  always #5 clk = ~clk;

  // Single-port RAM with 1-cycle read latency, read-before-write.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model state.
  logic [31:0] mmem [256];
  op_t         pq[$];
  resp_t       rq[3][$];   // 0 fetch, 1 load, 2 store
  int          streak = 0;
  bit          merr = 0;
  logic        exp_en = 0, exp_st = 0, exp_err = 0;
  logic [3:0]  exp_we = '0;
  logic [31:0] exp_addr = '0, exp_wd = '0;

  task automatic flush();
    pq.delete();
    for (int c = 0; c < 3; c++) rq[c].delete();
    streak = 0; merr = 0;
    exp_en = 0; exp_st = 0; exp_err = 0; exp_we = '0; exp_addr = '0; exp_wd = '0;
  endtask

  task automatic cycle(input bit ld, input bit st, input bit rd, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] sel);
    op_t inc, head;
    bit has_inc, has_head, dgrant;
    logic [7:0] idx;
    @(posedge clk); #1;
    dm_load = ld; dm_store = st; im_rd = rd; im_addr = ia;
    dm_addr = da; dm_wdata = wd; dm_sel = sel;
    exp_err = merr;
    exp_en = 0; exp_st = 0; exp_we = '0; exp_addr = '0; exp_wd = '0;
    has_inc = ld ^ st;
    inc = '{st: st, addr: da, data: wd, sel: sel};
    if (ld && st) merr = 1;
    has_head = (pq.size() > 0) || has_inc;
    head = (pq.size() > 0) ? pq[0] : inc;
    dgrant = has_head && (!rd || streak < int'(MB));
    if (dgrant) begin
      if (pq.size() > 0) void'(pq.pop_front());
      else has_inc = 0;
      idx = head.addr[AW+1:2];
      exp_en = 1; exp_addr = 32'(idx);
      if (head.st) begin
        exp_st = 1; exp_we = head.sel; exp_wd = head.data;
        for (int b = 0; b < 4; b++)
          if (head.sel[b]) mmem[idx][8*b +: 8] = head.data[8*b +: 8];
        rq[2].push_back('{data: 32'h0, cyc: 32'(cyc)});
      end else begin
        rq[1].push_back('{data: mmem[idx], cyc: 32'(cyc)});
      end
      if (!rd) streak = 0;
      else if (streak < 15) streak++;
    end else if (rd) begin
      idx = ia[AW+1:2];
      exp_en = 1; exp_addr = 32'(idx);
      rq[0].push_back('{data: mmem[idx], cyc: 32'(cyc)});
      streak = 0;
    end else begin
      streak = 0;
    end
    if (has_inc) begin
      if (pq.size() == 0) pq.push_back(inc);
      else merr = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    dm_load = 0; dm_store = 0; im_rd = 0;
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Monitor: per-cycle RAM drive and scoreboard pops on every return pulse.
  always @(negedge clk) begin
    logic [2:0] vld;
    logic [31:0] dat [3];
    resp_t r;
    if (!rst_n) begin
      chk("reset_ctrl", {23'd0, im_valid, load_done, store_done, mem_en, mem_we, err}, '0);
      chk("reset_data", im_data | dm_rdata | mem_wdata | 32'(mem_addr), '0);
    end else begin
      chk("mem_en", 32'(mem_en), 32'(exp_en));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_en) chk("mem_addr", 32'(mem_addr), exp_addr);
      if (exp_st) chk("mem_wdata", mem_wdata, exp_wd);
      chk("err", 32'(err), 32'(exp_err));
      vld = {store_done, load_done, im_valid};
      dat[0] = im_data; dat[1] = dm_rdata; dat[2] = 32'h0;
      for (int c = 0; c < 3; c++) begin
        if (vld[c]) begin
          if (rq[c].size() == 0) begin
            chk($sformatf("spurious_pulse_ch%0d", c), 32'd1, 32'd0);
          end else begin
            r = rq[c].pop_front();
            chk($sformatf("ret_data_ch%0d", c), dat[c], r.data);
            chk($sformatf("ret_latency_ch%0d", c), 32'(cyc), r.cyc + 1);
          end
        end else begin
          chk($sformatf("idle_data_zero_ch%0d", c), dat[c], '0);
          if (rq[c].size() > 0 && rq[c][0].cyc + 1 <= 32'(cyc)) begin
            r = rq[c].pop_front();
            chk($sformatf("missing_pulse_ch%0d", c), 32'd0, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]  = (i == 64) ? 32'h0 : (32'(i) * 32'h0101_0101) ^ 32'h5A00_0000;
      mmem[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Plain fetch stream.
    cycle(0, 0, 1, 32'h0, '0, '0, '0);
    cycle(0, 0, 1, 32'h4, '0, '0, '0);
    cycle(0, 0, 1, 32'h8, '0, '0, '0);
    idle(2);

    // Partial store then load-back of the same word.
    cycle(0, 1, 0, '0, 32'h100, 32'hDEAD_BEEF, 4'b0011);
    idle(1);
    cycle(1, 0, 0, '0, 32'h100, '0, '0);
    idle(2);

    // Burst limiter: six back-to-back loads against a waiting fetch.
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 32'h20, 32'h100 + 32'(4 * i), '0, '0);
    idle(3);

    // Randomised mix; the address masks force aliasing and exercise ignored bits.
    for (int i = 0; i < 2000; i++) begin
      int r = $urandom_range(0, 7);
      cycle(r == 0, r == 1, $urandom_range(0, 3) != 0,
            $urandom & 32'hFFFF_F03F, $urandom & 32'hFFFF_F03F, $urandom, 4'($urandom));
    end
    idle(3);

    // Simultaneous load and store pulse.
    do_reset();
    cycle(1, 1, 0, '0, 32'h40, 32'h1234_5678, 4'hF);
    idle(3);

    // Slot occupied while the fetch wins, with another pulse arriving.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 32'h30, 32'h200 + 32'(4 * i), '0, '0);
    idle(3);

    // Reset between a load grant and its completion.
    do_reset();
    cycle(1, 0, 0, '0, 32'h100, '0, '0);
    #2 rst_n = 0;
    dm_load = 0;
    flush();
    #1;
    chk("midreset_mem_en", 32'(mem_en), 32'd0);
    chk("midreset_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle(3);

    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) chk($sformatf("drain_ch%0d", c), 32'(rq[c].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
